// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch sequencer with one-entry skid buffer and redirect squash
// ports: clock/reset (sync, active-high); action/action_valid/action_pc/action_imm redirect input;
//        imem_req/imem_addr/imem_ack/imem_rdata fetch port; if_valid/if_instr/if_pc/if_ready decode port
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  action,
  input  logic        action_valid,
  input  logic [31:0] action_pc,
  input  logic [25:0] action_imm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_addr, r_instr, r_ipc, r_skid_instr, r_skid_pc;
  logic        r_valid, r_skid_v, r_squash;
  logic [31:0] w_pc4, w_target;
  logic        w_redir, w_cons, w_take;
  assign w_pc4    = action_pc + 32'd4;
  assign w_target = action[0] ? w_pc4 + {{14{action_imm[15]}}, action_imm[15:0], 2'b00}
                              : {w_pc4[31:28], action_imm, 2'b00};
  assign w_redir  = action_valid && action[1];
  assign w_cons   = r_valid && if_ready;
  assign w_take   = (r_state == FETCH) && imem_ack && !w_redir;
  assign if_valid = r_valid;
  assign if_instr = r_instr;
  assign if_pc    = r_ipc;
  always_ff @(posedge clock)
    r_state <= reset ? BOOT : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      BOOT:  w_next = FETCH;
      FETCH: w_next = w_redir ? (imem_ack ? FETCH : DRAIN) : (w_take && r_valid && !w_cons ? HOLD : FETCH);
      HOLD:  w_next = (w_redir || w_cons) ? FETCH : HOLD;
      DRAIN: w_next = imem_ack ? FETCH : DRAIN;
      default: w_next = BOOT;
    endcase
  end
  // while squashing, the outstanding request stays at the pre-redirect address
  always_comb begin
    imem_req  = (r_state == FETCH) || (r_state == DRAIN);
    imem_addr = r_squash ? r_addr : r_pc;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_addr       <= '0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_ipc        <= '0;
      r_skid_v     <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_squash     <= 1'b0;
    end else begin
      if (w_redir) begin
        r_pc     <= w_target;
        r_valid  <= 1'b0;
        r_skid_v <= 1'b0;
      end else begin
        if (w_take)
          r_pc <= r_pc + 32'd4;
        if (w_take && (!r_valid || w_cons)) begin
          r_valid <= 1'b1;
          r_instr <= imem_rdata;
          r_ipc   <= r_pc;
        end else if (r_state == HOLD && w_cons) begin
          r_instr  <= r_skid_instr;
          r_ipc    <= r_skid_pc;
          r_skid_v <= 1'b0;
        end else if (w_cons)
          r_valid <= 1'b0;
        if (w_take && r_valid && !w_cons) begin
          r_skid_v     <= 1'b1;
          r_skid_instr <= imem_rdata;
          r_skid_pc    <= r_pc;
        end
      end
      if (r_state == FETCH && w_redir && !imem_ack) begin
        r_squash <= 1'b1;
        r_addr   <= r_pc;
      end else if (r_state == DRAIN && imem_ack)
        r_squash <= 1'b0;
    end
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 32'h0040_0000, PC loaded on reset.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: action  input  2  Pc_Action code from branch resolution: None=0, Inc=1, Jump=2, Branch=3.
REQ-005 Port: action_valid  input  1  action/action_pc/action_imm meaningful this cycle; single-cycle pulse.
REQ-006 Port: action_pc  input  32  PC of the resolving jump/branch instruction.
REQ-007 Port: action_imm  input  26  instruction immediate field: low 16 bits for Branch, all 26 for Jump.
REQ-008 Port: imem_req  output  1  fetch request to instruction memory.
REQ-009 Port: imem_addr  output  32  fetch word address; held stable while imem_req=1 and imem_ack=0.
REQ-010 Port: imem_ack  input  1  request accepted; imem_rdata valid in the same cycle.
REQ-011 Port: imem_rdata  input  32  fetched instruction word.
REQ-012 Port: if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-013 Port: if_instr  output  32  instruction to decode.
REQ-014 Port: if_pc  output  32  address of if_instr.
REQ-015 Port: if_ready  input  1  decode consumes if_instr when if_valid=1 and if_ready=1; 0 = stall.

Function
REQ-016 State: pc (32), out register (if_valid/if_instr/if_pc), one-entry skid buffer, squash flag, FSM {BOOT, FETCH, HOLD, DRAIN}.
REQ-017 BOOT: imem_req=0; always -> FETCH next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=pc.
REQ-019 FETCH with ack, no redirect: word goes to out register if it is empty or consumed this cycle, else to skid buffer; pc <= pc+4 (modulo 2^32); skid loaded -> HOLD, else stay FETCH.
REQ-020 HOLD: imem_req=0; on consume, skid entry moves to out register same edge -> FETCH.
REQ-021 Redirect = action_valid and action in {Jump, Branch}; None and Inc are no redirect; sequential fetch continues.
REQ-022 Branch target = action_pc + 4 + (sign_extend(action_imm[15:0]) << 2), 32-bit wraparound.
REQ-023 Jump target = {action_pc_plus4[31:28], action_imm[25:0], 2'b00}, where action_pc_plus4 = action_pc + 4.
REQ-024 On redirect: pc <= target; if_valid and skid entry cleared next edge (no delay slot); redirect overrides any simultaneous consume/ack data.
REQ-025 Redirect in FETCH with no ack that cycle: request held at old address, squash set, -> DRAIN.
REQ-026 DRAIN: imem_req=1 at old address; on ack, data discarded, squash cleared -> FETCH at target next cycle.
REQ-027 Redirect in FETCH with ack same cycle: data discarded, stay FETCH, next imem_addr = target.
REQ-028 Redirect in HOLD or BOOT: -> FETCH (BOOT: -> FETCH as normal) with pc = target.
REQ-029 Second redirect during DRAIN: pc <= newer target; remain DRAIN.
REQ-030 if_instr/if_pc stable while if_valid=1 and if_ready=0 (unless redirect flushes).
REQ-031 Throughput: one instruction per cycle with ack=1 and if_ready=1 every cycle; fetch-to-if_valid latency one cycle.

Reset
REQ-032 Reset at any cycle, including mid-DRAIN or mid-FETCH: state <= BOOT, pc <= RESET_PC, if_valid=0, skid empty, squash=0, imem_req=0, if_instr=0, if_pc=0 next cycle.
REQ-033 Reset overrides simultaneous action_valid, imem_ack, if_ready.
REQ-034 First imem_req rises two cycles after reset deasserts (BOOT, then FETCH).

Verification
REQ-035 Reset, ack and if_ready tied 1 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; if_pc follows one cycle later.
REQ-036 Branch, action_pc=0x00400010, imm=0xFFFC -> if_valid=0 next cycle; next imem_addr=0x00400004.
REQ-037 Jump, action_pc=0x00400020, imm=26'h0100000 -> next imem_addr=0x00400000; in-flight word dropped.
REQ-038 if_ready=0 for 3 cycles, ack=1 -> if_pc/if_instr constant; one word in skid; imem_req=0 from second stall cycle; after release, words delivered in order with no loss or duplication.
REQ-039 Branch during fetch with ack delayed 2 cycles -> imem_addr held; returned word never appears on if_instr; next request at branch target.
REQ-040 Reset asserted in DRAIN -> if_valid=0, imem_req=0 next cycle; first request after release at 0x00400000.
